// File: rtl/tsc_pkg.sv
// Shared colour and state encodings for the highway/country-road signal controller.
package tsc_pkg;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  typedef enum logic [2:0] {
    S0_HWY_GREEN   = 3'd0,
    S1_HWY_YELLOW  = 3'd1,
    S2_ALL_RED     = 3'd2,
    S3_CTRY_GREEN  = 3'd3,
    S4_CTRY_YELLOW = 3'd4
  } tsc_state_e;

  function automatic int tsc_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tsc_interval_timer.sv
// Loadable down-counter for the timed controller states; done_o is high once the count reaches zero.
module tsc_interval_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/traffic_signal_controller.sv
// Moore FSM for a highway/country-road intersection. Define TSC_MAX_GREEN_EN to cap
// country green at MAX_CTRY_GREEN cycles and hold highway green for Y2R_DELAY cycles afterwards.
module traffic_signal_controller
  import tsc_pkg::*;
#(
  parameter int Y2R_DELAY      = 3,
  parameter int R2G_DELAY      = 2,
  parameter int MAX_CTRY_GREEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       x,
  output logic [1:0] hwy,
  output logic [1:0] country
);

  localparam int MAX_DLY = tsc_max3(Y2R_DELAY, R2G_DELAY, MAX_CTRY_GREEN);
  localparam int CNT_W   = (MAX_DLY > 1) ? $clog2(MAX_DLY + 1) : 1;

  // The timer is loaded with N-1 on entry so a timed state lasts exactly N clocks.
  localparam logic [CNT_W-1:0] Y2R_LOAD = CNT_W'(Y2R_DELAY - 1);
  localparam logic [CNT_W-1:0] R2G_LOAD = CNT_W'(R2G_DELAY - 1);
`ifdef TSC_MAX_GREEN_EN
  localparam logic [CNT_W-1:0] MAXG_LOAD = CNT_W'(MAX_CTRY_GREEN - 1);
`endif

  tsc_state_e       state_q, state_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  tsc_interval_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .clr_n      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S0_HWY_GREEN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      S0_HWY_GREEN: begin
`ifdef TSC_MAX_GREEN_EN
        if (x && tmr_done) begin
`else
        if (x) begin
`endif
          state_d  = S1_HWY_YELLOW;
          tmr_load = 1'b1;
          tmr_val  = Y2R_LOAD;
        end
      end
      S1_HWY_YELLOW: begin
        if (tmr_done) begin
          state_d  = S2_ALL_RED;
          tmr_load = 1'b1;
          tmr_val  = R2G_LOAD;
        end
      end
      S2_ALL_RED: begin
        if (tmr_done) begin
          state_d = S3_CTRY_GREEN;
`ifdef TSC_MAX_GREEN_EN
          tmr_load = 1'b1;
          tmr_val  = MAXG_LOAD;
`endif
        end
      end
      S3_CTRY_GREEN: begin
`ifdef TSC_MAX_GREEN_EN
        if (!x || tmr_done) begin
`else
        if (!x) begin
`endif
          state_d  = S4_CTRY_YELLOW;
          tmr_load = 1'b1;
          tmr_val  = Y2R_LOAD;
        end
      end
      S4_CTRY_YELLOW: begin
        if (tmr_done) begin
          state_d = S0_HWY_GREEN;
`ifdef TSC_MAX_GREEN_EN
          // Highway hold-off before country may request again.
          tmr_load = 1'b1;
          tmr_val  = Y2R_LOAD;
`endif
        end
      end
      default: state_d = S0_HWY_GREEN;
    endcase
  end

  always_comb begin
    hwy     = RED;
    country = RED;
    case (state_q)
      S0_HWY_GREEN:   hwy     = GREEN;
      S1_HWY_YELLOW:  hwy     = YELLOW;
      S3_CTRY_GREEN:  country = GREEN;
      S4_CTRY_YELLOW: country = YELLOW;
      default:        ;
    endcase
  end

endmodule

// File: tb/tb_traffic_signal_controller.sv
// Directed bench for traffic_signal_controller; the max-green scenario is built only with TSC_MAX_GREEN_EN.
module tb_traffic_signal_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       x;
  logic [1:0] hwy;
  logic [1:0] country;

  int n_cmp = 0;
  int n_bad = 0;

  traffic_signal_controller dut (
    .clk     (clk),
    .reset   (reset),
    .x       (x),
    .hwy     (hwy),
    .country (country)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic expect_run(input int n, input logic [1:0] h, input logic [1:0] c, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_val({tag, "_hwy"}, hwy, h);
      check_val({tag, "_ctry"}, country, c);
      $display("[%0t] %s cyc %0d: x=%0b hwy=%0d country=%0d", $time, tag, i, x, hwy, country);
    end
  endtask

  // Safety invariants, sampled on the inactive edge while out of reset.
  logic [1:0] prev_h, prev_c;
  logic       prev_ok = 1'b0;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check_val("safe_both_go", {1'b0, (hwy != 2'd0) && (country != 2'd0)}, 2'd0);
      if (prev_ok) begin
        check_val("hwy_g2r", {1'b0, (prev_h == 2'd2) && (hwy == 2'd0)}, 2'd0);
        check_val("ctry_g2r", {1'b0, (prev_c == 2'd2) && (country == 2'd0)}, 2'd0);
      end
      prev_h  = hwy;
      prev_c  = country;
      prev_ok = 1'b1;
    end else begin
      prev_ok = 1'b0;
    end
  end

  initial begin
    reset = 1'b0;
    x     = 1'b0;
    #1;
    check_val("rst_async_hwy", hwy, 2'd2);
    check_val("rst_async_ctry", country, 2'd0);
    expect_run(5, 2'd2, 2'd0, "rst_hold");
    reset = 1'b1;
    expect_run(20, 2'd2, 2'd0, "post_rst");

    // Full cycle: x high for 10 edges
    x = 1'b1;
    expect_run(3, 2'd1, 2'd0, "full_y");
    expect_run(2, 2'd0, 2'd0, "full_ar");
    expect_run(5, 2'd0, 2'd2, "full_cg");
    x = 1'b0;
    expect_run(3, 2'd0, 2'd1, "full_cy");
    expect_run(5, 2'd2, 2'd0, "full_hg");

    // One-cycle pulse still runs the whole sequence
    x = 1'b1;
    expect_run(1, 2'd1, 2'd0, "pulse_y0");
    x = 1'b0;
    expect_run(2, 2'd1, 2'd0, "pulse_y");
    expect_run(2, 2'd0, 2'd0, "pulse_ar");
    expect_run(1, 2'd0, 2'd2, "pulse_cg");
    expect_run(3, 2'd0, 2'd1, "pulse_cy");
    expect_run(5, 2'd2, 2'd0, "pulse_hg");

    // Asynchronous reset in S1
    x = 1'b1;
    expect_run(1, 2'd1, 2'd0, "s1_y");
    x = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_val("s1_arst_hwy", hwy, 2'd2);
    check_val("s1_arst_ctry", country, 2'd0);
    expect_run(2, 2'd2, 2'd0, "s1_rst_hold");
    reset = 1'b1;
    expect_run(5, 2'd2, 2'd0, "s1_post");

    // Asynchronous reset in S3
    x = 1'b1;
    expect_run(3, 2'd1, 2'd0, "s3_y");
    expect_run(2, 2'd0, 2'd0, "s3_ar");
    expect_run(2, 2'd0, 2'd2, "s3_cg");
    x = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_val("s3_arst_hwy", hwy, 2'd2);
    check_val("s3_arst_ctry", country, 2'd0);
    expect_run(2, 2'd2, 2'd0, "s3_rst_hold");
    reset = 1'b1;
    expect_run(5, 2'd2, 2'd0, "s3_post");

`ifdef TSC_MAX_GREEN_EN
    // Country green capped, then highway hold-off before the next yellow
    x = 1'b1;
    expect_run(3, 2'd1, 2'd0, "mg_y");
    expect_run(2, 2'd0, 2'd0, "mg_ar");
    expect_run(8, 2'd0, 2'd2, "mg_cg");
    expect_run(3, 2'd0, 2'd1, "mg_cy");
    expect_run(3, 2'd2, 2'd0, "mg_hold");
    expect_run(1, 2'd1, 2'd0, "mg_y2");
    x = 1'b0;
    expect_run(2, 2'd1, 2'd0, "mg_y2b");
    expect_run(2, 2'd0, 2'd0, "mg_ar2");
    expect_run(1, 2'd0, 2'd2, "mg_cg2");
    expect_run(3, 2'd0, 2'd1, "mg_cy2");
    expect_run(5, 2'd2, 2'd0, "mg_end");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
